// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: multi-slice MEM/WB pipeline register.
//
// Carries write-back control, memory read data, ALU result and destination
// register through STAGES register slices (1..4). Adds a per-slice valid bit,
// stall/flush control, x0 write suppression, a muxed write-back result, a
// forwarding lookup across all slices and a retired-instruction counter.
//
// Ports:
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   stall_i, flush_i        hold all slices / invalidate all slices
//   valid_i, WB_i, Data_i,
//   ALUout_i, RDaddr_i      incoming MEM-stage entry (WB_i = {RegWrite, MemtoReg})
//   valid_o, RegWrite_o,
//   MemtoReg_o, Data_o,
//   ALUout_o, RDaddr_o,
//   WBdata_o                output slice, control qualified by valid and x0
//   fwd_addr_i, fwd_hit_o,
//   fwd_data_o              forwarding lookup, youngest matching slice wins
//   retire_cnt_o            valid entries consumed by the register file
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int STAGES = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [1:0]        WB_i,
  input  logic [DATA_W-1:0] Data_i,
  input  logic [DATA_W-1:0] ALUout_i,
  input  logic [ADDR_W-1:0] RDaddr_i,
  output logic              valid_o,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic [DATA_W-1:0] Data_o,
  output logic [DATA_W-1:0] ALUout_o,
  output logic [ADDR_W-1:0] RDaddr_o,
  output logic [DATA_W-1:0] WBdata_o,
  input  logic [ADDR_W-1:0] fwd_addr_i,
  output logic              fwd_hit_o,
  output logic [DATA_W-1:0] fwd_data_o,
  output logic [CNT_W-1:0]  retire_cnt_o
);

  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0]             r_valid;
  logic [STAGES-1:0][1:0]        r_wb;
  logic [STAGES-1:0][DATA_W-1:0] r_data;
  logic [STAGES-1:0][DATA_W-1:0] r_alu;
  logic [STAGES-1:0][ADDR_W-1:0] r_rd;
  logic [CNT_W-1:0]              r_retire_cnt;

  // What each slice would capture on a normal shift.
  logic [STAGES-1:0]             w_nxt_valid;
  logic [STAGES-1:0][1:0]        w_nxt_wb;
  logic [STAGES-1:0][DATA_W-1:0] w_nxt_data;
  logic [STAGES-1:0][DATA_W-1:0] w_nxt_alu;
  logic [STAGES-1:0][ADDR_W-1:0] w_nxt_rd;

  logic              w_fwd_hit;
  logic [DATA_W-1:0] w_fwd_data;

  always_comb begin
    w_nxt_valid    = '0;
    w_nxt_wb       = '0;
    w_nxt_data     = '0;
    w_nxt_alu      = '0;
    w_nxt_rd       = '0;
    w_nxt_valid[0] = valid_i;
    w_nxt_wb[0]    = WB_i;
    w_nxt_data[0]  = Data_i;
    w_nxt_alu[0]   = ALUout_i;
    w_nxt_rd[0]    = RDaddr_i;
    for (int k = 1; k < STAGES; k++) begin
      w_nxt_valid[k] = r_valid[k-1];
      w_nxt_wb[k]    = r_wb[k-1];
      w_nxt_data[k]  = r_data[k-1];
      w_nxt_alu[k]   = r_alu[k-1];
      w_nxt_rd[k]    = r_rd[k-1];
    end
  end

  // Flush kills control but lets payload keep shifting; it is don't-care
  // once the valid bit is low, and shifting avoids a second enable path.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid <= '0;
      r_wb    <= '0;
      r_data  <= '0;
      r_alu   <= '0;
      r_rd    <= '0;
    end else if (flush_i) begin
      r_valid <= '0;
      r_wb    <= '0;
      r_data  <= w_nxt_data;
      r_alu   <= w_nxt_alu;
      r_rd    <= w_nxt_rd;
    end else if (!stall_i) begin
      r_valid <= w_nxt_valid;
      r_wb    <= w_nxt_wb;
      r_data  <= w_nxt_data;
      r_alu   <= w_nxt_alu;
      r_rd    <= w_nxt_rd;
    end
  end

  // The output entry is written to the register file at any non-stalled
  // edge, flush included, so it counts as retired there.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_retire_cnt <= '0;
    end else if (r_valid[LAST] && !stall_i) begin
      r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  // Scan oldest to youngest so the lowest-index hit is the last assignment.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (r_valid[k] && r_wb[k][1] && (r_rd[k] == fwd_addr_i) && (r_rd[k] != '0)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_wb[k][0] ? r_data[k] : r_alu[k];
      end
    end
  end

  assign valid_o      = r_valid[LAST];
  assign RegWrite_o   = r_valid[LAST] & r_wb[LAST][1] & (r_rd[LAST] != '0);
  assign MemtoReg_o   = r_valid[LAST] & r_wb[LAST][0];
  assign Data_o       = r_data[LAST];
  assign ALUout_o     = r_alu[LAST];
  assign RDaddr_o     = r_rd[LAST];
  assign WBdata_o     = MemtoReg_o ? r_data[LAST] : r_alu[LAST];
  assign fwd_hit_o    = w_fwd_hit;
  assign fwd_data_o   = w_fwd_data;
  assign retire_cnt_o = r_retire_cnt;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Testbench for mem_wb_pipe: three instances (STAGES 1/2/3) share one
// stimulus stream and are compared every cycle against a queue-of-entries
// reference model, plus directed constant checks for the key scenarios.
module tb_mem_wb_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, flush, valid;
  logic [1:0]  wb;
  logic [31:0] data, alu;
  logic [4:0]  rd, fwd_addr;

  logic        o_valid [3];
  logic        o_rw    [3];
  logic        o_m2r   [3];
  logic        o_hit   [3];
  logic [31:0] o_data  [3];
  logic [31:0] o_alu   [3];
  logic [31:0] o_wbd   [3];
  logic [31:0] o_fd    [3];
  logic [4:0]  o_rd    [3];
  logic [3:0]  cnt1, cnt3;
  logic [31:0] cnt2;

  mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .STAGES(1), .CNT_W(4)) u_s1 (
    .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .flush_i(flush),
    .valid_i(valid), .WB_i(wb), .Data_i(data), .ALUout_i(alu), .RDaddr_i(rd),
    .valid_o(o_valid[0]), .RegWrite_o(o_rw[0]), .MemtoReg_o(o_m2r[0]),
    .Data_o(o_data[0]), .ALUout_o(o_alu[0]), .RDaddr_o(o_rd[0]),
    .WBdata_o(o_wbd[0]), .fwd_addr_i(fwd_addr), .fwd_hit_o(o_hit[0]),
    .fwd_data_o(o_fd[0]), .retire_cnt_o(cnt1));

  mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .STAGES(2), .CNT_W(32)) u_s2 (
    .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .flush_i(flush),
    .valid_i(valid), .WB_i(wb), .Data_i(data), .ALUout_i(alu), .RDaddr_i(rd),
    .valid_o(o_valid[1]), .RegWrite_o(o_rw[1]), .MemtoReg_o(o_m2r[1]),
    .Data_o(o_data[1]), .ALUout_o(o_alu[1]), .RDaddr_o(o_rd[1]),
    .WBdata_o(o_wbd[1]), .fwd_addr_i(fwd_addr), .fwd_hit_o(o_hit[1]),
    .fwd_data_o(o_fd[1]), .retire_cnt_o(cnt2));

  mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .STAGES(3), .CNT_W(4)) u_s3 (
    .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .flush_i(flush),
    .valid_i(valid), .WB_i(wb), .Data_i(data), .ALUout_i(alu), .RDaddr_i(rd),
    .valid_o(o_valid[2]), .RegWrite_o(o_rw[2]), .MemtoReg_o(o_m2r[2]),
    .Data_o(o_data[2]), .ALUout_o(o_alu[2]), .RDaddr_o(o_rd[2]),
    .WBdata_o(o_wbd[2]), .fwd_addr_i(fwd_addr), .fwd_hit_o(o_hit[2]),
    .fwd_data_o(o_fd[2]), .retire_cnt_o(cnt3));

  // Reference model: each pipe is a list of entries, index 0 youngest.
  typedef struct {
    logic        v;
    logic [1:0]  wb;
    logic [31:0] d;
    logic [31:0] a;
    logic [4:0]  rd;
  } ent_t;

  ent_t        pipe  [3][4];
  int unsigned mcnt  [3];
  int          depth [3] = '{1, 2, 3};
  int unsigned cmask [3] = '{32'h0000_000F, 32'hFFFF_FFFF, 32'h0000_000F};

  int n_checks = 0;
  int n_errors = 0;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      mcnt[i] = 0;
      for (int k = 0; k < 4; k++) pipe[i][k] = '{1'b0, 2'b00, 32'h0, 32'h0, 5'h0};
    end
  endfunction

  function automatic void model_edge();
    ent_t inc;
    inc = '{valid, wb, data, alu, rd};
    for (int i = 0; i < 3; i++) begin
      if (pipe[i][depth[i]-1].v && !stall) mcnt[i] = (mcnt[i] + 1) & cmask[i];
      if (flush || !stall) begin
        for (int k = depth[i] - 1; k > 0; k--) pipe[i][k] = pipe[i][k-1];
        pipe[i][0] = inc;
        if (flush)
          for (int k = 0; k < depth[i]; k++) begin
            pipe[i][k].v  = 1'b0;
            pipe[i][k].wb = 2'b00;
          end
      end
    end
  endfunction

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s [STAGES=%0d] observed=%h expected=%h", tag, depth[i], obs, exp);
    end
  endtask

  task automatic check_pipes(input string tag);
    ent_t        e;
    logic        rw, m2r, hit;
    logic [31:0] fd, cnt_obs;
    for (int i = 0; i < 3; i++) begin
      e   = pipe[i][depth[i]-1];
      rw  = e.v & e.wb[1] & (e.rd != 5'd0);
      m2r = e.v & e.wb[0];
      hit = 1'b0;
      fd  = 32'h0;
      for (int k = 0; k < depth[i]; k++)
        if (!hit && pipe[i][k].v && pipe[i][k].wb[1] && pipe[i][k].rd == fwd_addr && fwd_addr != 5'd0) begin
          hit = 1'b1;
          fd  = pipe[i][k].wb[0] ? pipe[i][k].d : pipe[i][k].a;
        end
      cnt_obs = (i == 0) ? {28'h0, cnt1} : (i == 1) ? cnt2 : {28'h0, cnt3};
      chk({tag, ".valid"}, i, {31'h0, o_valid[i]}, {31'h0, e.v});
      chk({tag, ".regwrite"}, i, {31'h0, o_rw[i]}, {31'h0, rw});
      chk({tag, ".memtoreg"}, i, {31'h0, o_m2r[i]}, {31'h0, m2r});
      chk({tag, ".data"}, i, o_data[i], e.d);
      chk({tag, ".alu"}, i, o_alu[i], e.a);
      chk({tag, ".rd"}, i, {27'h0, o_rd[i]}, {27'h0, e.rd});
      chk({tag, ".wbdata"}, i, o_wbd[i], m2r ? e.d : e.a);
      chk({tag, ".fwd_hit"}, i, {31'h0, o_hit[i]}, {31'h0, hit});
      chk({tag, ".fwd_data"}, i, o_fd[i], fd);
      chk({tag, ".retire"}, i, cnt_obs, mcnt[i]);
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    #1;
    model_edge();
    check_pipes(tag);
  endtask

  task automatic idle();
    valid = 1'b0; wb = 2'b00; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic put(input logic [1:0] w, input logic [31:0] d, input logic [31:0] a, input logic [4:0] r);
    valid = 1'b1; wb = w; data = d; alu = a; rd = r;
  endtask

  // Reset pulse placed between edges; outputs must drop before the next edge.
  task automatic reset_pulse(input string tag);
    @(posedge clk);
    #1;
    model_edge();
    rst_n = 1'b0;
    #2;
    model_reset();
    check_pipes(tag);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; valid = 1'b0; wb = 2'b00;
    data = 32'h0; alu = 32'h0; rd = 5'd0; fwd_addr = 5'd0;
    model_reset();
    #3;
    check_pipes("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single write-back entry through all depths.
    put(2'b10, 32'h0, 32'h1234, 5'd7);
    cyc("t1.e1");
    idle();
    cyc("t1.e2");
    chk("t1.valid_e2", 1, {31'h0, o_valid[1]}, 32'h1);
    chk("t1.regwrite_e2", 1, {31'h0, o_rw[1]}, 32'h1);
    chk("t1.wbdata_e2", 1, o_wbd[1], 32'h1234);
    chk("t1.rd_e2", 1, {27'h0, o_rd[1]}, 32'd7);
    cyc("t1.e3");
    chk("t1.valid_e3", 1, {31'h0, o_valid[1]}, 32'h0);
    chk("t1.retire_e3", 1, cnt2, 32'd1);

    // Load to x0: no register write, memory data still muxed out.
    reset_pulse("t2.reset");
    fwd_addr = 5'd0;
    put(2'b11, 32'hCAFE, 32'h55, 5'd0);
    cyc("t2.e1");
    chk("t2.regwrite", 0, {31'h0, o_rw[0]}, 32'h0);
    chk("t2.memtoreg", 0, {31'h0, o_m2r[0]}, 32'h1);
    chk("t2.wbdata", 0, o_wbd[0], 32'hCAFE);
    chk("t2.fwd_hit_x0", 0, {31'h0, o_hit[0]}, 32'h0);

    // Forwarding priority across slices.
    reset_pulse("t3.reset");
    fwd_addr = 5'd5;
    put(2'b10, 32'h0, 32'hB, 5'd5);  cyc("t3.e1");
    put(2'b10, 32'h0, 32'h77, 5'd9); cyc("t3.e2");
    put(2'b10, 32'h0, 32'hA, 5'd5);  cyc("t3.e3");
    chk("t3.hit_young", 2, {31'h0, o_hit[2]}, 32'h1);
    chk("t3.data_young", 2, o_fd[2], 32'hA);
    reset_pulse("t3.reset2");
    put(2'b10, 32'h0, 32'hB, 5'd5);  cyc("t3.f1");
    put(2'b00, 32'h0, 32'hA, 5'd5);  cyc("t3.f2");
    idle();                          cyc("t3.f3");
    chk("t3.data_old", 2, o_fd[2], 32'hB);

    // Stall holds everything, then stall+flush: flush wins, no retire.
    for (int n = 0; n < 3; n++) begin
      put(2'b10, 32'h0, 32'h100 + n, 5'd3);
      cyc("t4.fill");
    end
    stall = 1'b1;
    for (int n = 0; n < 3; n++) cyc("t4.stall");
    flush = 1'b1;
    cyc("t4.stall_flush");
    for (int i = 0; i < 3; i++) begin
      chk("t4.valid_flushed", i, {31'h0, o_valid[i]}, 32'h0);
      chk("t4.hit_flushed", i, {31'h0, o_hit[i]}, 32'h0);
    end
    idle();

    // Mid-stream asynchronous reset.
    put(2'b10, 32'h0, 32'h42, 5'd4);
    cyc("t5.a"); cyc("t5.b"); cyc("t5.c");
    reset_pulse("t5.reset");
    chk("t5.retire", 1, cnt2, 32'h0);
    chk("t5.valid", 2, {31'h0, o_valid[2]}, 32'h0);

    // Counter wrap on the 4-bit counters after 17 retirements.
    for (int n = 0; n < 17; n++) begin
      put(2'b10, 32'h0, n, 5'd1);
      cyc("t6.fill");
    end
    idle();
    for (int n = 0; n < 3; n++) cyc("t6.drain");
    chk("t6.wrap_s1", 0, {28'h0, cnt1}, 32'd1);
    chk("t6.wrap_s3", 2, {28'h0, cnt3}, 32'd1);
    chk("t6.count_s2", 1, cnt2, 32'd17);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      valid    = ($urandom_range(0, 9) < 7);
      wb       = 2'($urandom_range(0, 3));
      data     = $urandom;
      alu      = $urandom;
      rd       = 5'($urandom_range(0, 7));
      fwd_addr = 5'($urandom_range(0, 7));
      stall    = ($urandom_range(0, 9) < 2);
      flush    = ($urandom_range(0, 9) < 1);
      cyc("rand");
    end
    idle();
    cyc("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
